// File: rtl/ram_arbiter.sv
// ram_arbiter: two-requester (Apple bus, CPU) arbiter in front of a single
// RAM controller command port. No grant is made until the RAM PLL lock has
// been stable for LOCK_WAIT cycles. Losing lock aborts the transaction in
// flight. The aborted requester keeps its request up and is arbitrated again
// after relock.
//
// Optional feature: define RAM_ARBITER_FAIRNESS_EN to allow a waiting CPU to
// win after STARVE_MAX consecutive Apple grants. When the macro is undefined,
// Apple always wins over the CPU.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// WAIT_LOCK | counting consecutive synchronized-lock cycles, ready=0
// IDLE      | lock qualified, arbitrating among pending requests
// ISSUE     | mem_req driven with the latched command, waiting for accept
// WAIT_DONE | command accepted, waiting for mem_done to ack the winner
`timescale 1ns/1ps

module ram_arbiter #(
    parameter int ADDR_W     = 22,
    parameter int DATA_W     = 16,
    parameter int LOCK_WAIT  = 255,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                pll_lock,

    input  logic                apl_req,
    input  logic                apl_we,
    input  logic [ADDR_W-1:0]   apl_addr,
    input  logic [DATA_W-1:0]   apl_wdata,
    input  logic [DATA_W/8-1:0] apl_wmask,
    output logic                apl_ack,

    input  logic                cpu_req,
    input  logic                cpu_we,
    input  logic [ADDR_W-1:0]   cpu_addr,
    input  logic [DATA_W-1:0]   cpu_wdata,
    input  logic [DATA_W/8-1:0] cpu_wmask,
    output logic                cpu_ack,

    output logic [DATA_W-1:0]   rdata,

    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_accept,
    input  logic                mem_done,
    input  logic [DATA_W-1:0]   mem_rdata,

    output logic                ready
);

    localparam int LC_W = (LOCK_WAIT < 2) ? 1 : $clog2(LOCK_WAIT + 1);

    if (LOCK_WAIT < 1 || STARVE_MAX < 1) begin : g_bad_params
        $error("ram_arbiter: LOCK_WAIT and STARVE_MAX must be at least 1");
    end

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        IDLE      = 2'd1,
        ISSUE     = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic [1:0]        lock_sync;
    logic              lock_s;
    logic [LC_W-1:0]   lock_cnt;
    logic              lock_done;

    logic              any_req;
    logic              pick_cpu;
    logic              grant;
    logic              complete;
    logic              owner_cpu;

    // two-flop synchronizer for the asynchronous PLL lock
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) lock_sync <= 2'b00;
        else          lock_sync <= {lock_sync[0], pll_lock};
    end

    assign lock_s    = lock_sync[1];
    assign lock_done = lock_s && (lock_cnt == LC_W'(LOCK_WAIT - 1));

    // count consecutive high lock cycles; cleared on any low cycle or outside WAIT_LOCK
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                                      lock_cnt <= '0;
        else if (state == WAIT_LOCK && lock_s && !lock_done) lock_cnt <= lock_cnt + 1'b1;
        else                                               lock_cnt <= '0;
    end

    assign any_req = apl_req | cpu_req;

`ifdef RAM_ARBITER_FAIRNESS_EN
    localparam int SC_W = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);
    logic [SC_W-1:0] starve_cnt;

    assign pick_cpu = cpu_req && (!apl_req || (starve_cnt == SC_W'(STARVE_MAX)));

    // consecutive Apple grants taken while the CPU was waiting
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            starve_cnt <= '0;
        end else if (grant) begin
            if (pick_cpu || !cpu_req) starve_cnt <= '0;
            else                      starve_cnt <= starve_cnt + 1'b1;
        end
    end
`else
    assign pick_cpu = cpu_req && !apl_req;
`endif

    // state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= WAIT_LOCK;
        else          state <= state_nxt;
    end

    // next state, grant/complete strobes and mem_req; lock loss overrides everything
    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        complete  = 1'b0;
        mem_req   = 1'b0;
        case (state)
            WAIT_LOCK: begin
                if (lock_done) state_nxt = IDLE;
            end
            IDLE: begin
                if (!lock_s) begin
                    state_nxt = WAIT_LOCK;
                end else if (any_req && !apl_ack && !cpu_ack) begin
                    // the ack cycle is skipped: its requester still shows req
                    grant     = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                mem_req = lock_s;
                if (!lock_s) begin
                    state_nxt = WAIT_LOCK;
                end else if (mem_accept) begin
                    if (mem_done) begin
                        complete  = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = WAIT_DONE;
                    end
                end
            end
            WAIT_DONE: begin
                if (!lock_s) begin
                    state_nxt = WAIT_LOCK;
                end else if (mem_done) begin
                    complete  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = WAIT_LOCK;
        endcase
    end

    // command register, loaded from the winner at grant time
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            owner_cpu <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wmask <= '0;
        end else if (grant) begin
            owner_cpu <= pick_cpu;
            mem_we    <= pick_cpu ? cpu_we    : apl_we;
            mem_addr  <= pick_cpu ? cpu_addr  : apl_addr;
            mem_wdata <= pick_cpu ? cpu_wdata : apl_wdata;
            mem_wmask <= pick_cpu ? cpu_wmask : apl_wmask;
        end
    end

    // completion: one-cycle ack to the owner, read data captured alongside
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            apl_ack <= 1'b0;
            cpu_ack <= 1'b0;
            rdata   <= '0;
        end else begin
            apl_ack <= complete && !owner_cpu;
            cpu_ack <= complete &&  owner_cpu;
            if (complete) rdata <= mem_rdata;
        end
    end

    // ready follows the state the FSM is entering
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) ready <= 1'b0;
        else          ready <= (state_nxt != WAIT_LOCK);
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed testbench for ram_arbiter: lock qualification, single read,
// simultaneous requests, same-cycle accept/done, lock loss and
// fairness (expectations follow RAM_ARBITER_FAIRNESS_EN).
`timescale 1ns/1ps

module tb_ram_arbiter;

    localparam int ADDR_W     = 22;
    localparam int DATA_W     = 16;
    localparam int LOCK_WAIT  = 255;
    localparam int STARVE_MAX = 4;

    logic                clk;
    logic                reset_n;
    logic                pll_lock;
    logic                apl_req, apl_we, apl_ack;
    logic [ADDR_W-1:0]   apl_addr;
    logic [DATA_W-1:0]   apl_wdata;
    logic [DATA_W/8-1:0] apl_wmask;
    logic                cpu_req, cpu_we, cpu_ack;
    logic [ADDR_W-1:0]   cpu_addr;
    logic [DATA_W-1:0]   cpu_wdata;
    logic [DATA_W/8-1:0] cpu_wmask;
    logic [DATA_W-1:0]   rdata;
    logic                mem_req, mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W/8-1:0] mem_wmask;
    logic                mem_accept, mem_done;
    logic [DATA_W-1:0]   mem_rdata;
    logic                ready;

    ram_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LOCK_WAIT(LOCK_WAIT), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk), .reset_n(reset_n), .pll_lock(pll_lock),
        .apl_req(apl_req), .apl_we(apl_we), .apl_addr(apl_addr),
        .apl_wdata(apl_wdata), .apl_wmask(apl_wmask), .apl_ack(apl_ack),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_wmask(cpu_wmask), .cpu_ack(cpu_ack),
        .rdata(rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_accept(mem_accept), .mem_done(mem_done), .mem_rdata(mem_rdata),
        .ready(ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   mem_req_rises = 0;
    int   apl_ack_cnt = 0;
    int   cpu_ack_cnt = 0;
    logic mem_req_q = 1'b0;
    int   r0;
    int   c0;
    bit   exp_cpu [6];

    always @(posedge clk) begin
        if (mem_req && !mem_req_q) mem_req_rises++;
        if (apl_ack) apl_ack_cnt++;
        if (cpu_ack) cpu_ack_cnt++;
        mem_req_q <= mem_req;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_mem_req(input string tag);
        int n = 0;
        while (!mem_req && n < 50) begin
            step();
            n++;
        end
        check(tag, 64'(mem_req), 64'd1);
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        bit early = 1'b0;
        while (!ready && n < 600) begin
            step();
            n++;
            if (!ready && mem_req) early = 1'b1;
        end
        check({tag, "_cycles"}, 64'(n), 64'(LOCK_WAIT + 2));
        check({tag, "_no_early_req"}, 64'(early), 64'd0);
    endtask

    // controller model: accept after acc_dly cycles, done after done_dly more
    task automatic do_txn(input int acc_dly, input int done_dly, input logic [15:0] rd, input bit same);
        repeat (acc_dly) step();
        mem_accept = 1'b1;
        if (same) begin
            mem_done  = 1'b1;
            mem_rdata = rd;
        end
        step();
        mem_accept = 1'b0;
        mem_done   = 1'b0;
        if (!same) begin
            repeat (done_dly) step();
            mem_done  = 1'b1;
            mem_rdata = rd;
            step();
            mem_done  = 1'b0;
        end
    endtask

    initial begin
`ifdef RAM_ARBITER_FAIRNESS_EN
        exp_cpu = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
`else
        exp_cpu = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
        reset_n = 1'b0; pll_lock = 1'b0;
        apl_req = 1'b0; apl_we = 1'b0; apl_addr = '0; apl_wdata = '0; apl_wmask = '0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_wmask = '0;
        mem_accept = 1'b0; mem_done = 1'b0; mem_rdata = '0;
        repeat (3) @(posedge clk);
        #1;

        // reset state
        check("rst_ready",   64'(ready),     64'd0);
        check("rst_mem_req", 64'(mem_req),   64'd0);
        check("rst_apl_ack", 64'(apl_ack),   64'd0);
        check("rst_cpu_ack", 64'(cpu_ack),   64'd0);
        check("rst_rdata",   64'(rdata),     64'd0);
        check("rst_addr",    64'(mem_addr),  64'd0);
        check("rst_wmask",   64'(mem_wmask), 64'd0);

        reset_n = 1'b1;
        step();

        // lock qualification with a one-cycle dropout; CPU read already pending
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 22'h012345;
        pll_lock = 1'b1;
        repeat (100) step();
        check("lock_not_ready_at_100", 64'(ready), 64'd0);
        pll_lock = 1'b0;
        step();
        pll_lock = 1'b1;
        wait_ready("lock_qual");

        // single read
        r0 = mem_req_rises;
        wait_mem_req("rd_req");
        check("rd_addr", 64'(mem_addr), 64'h012345);
        check("rd_we",   64'(mem_we),   64'd0);
        do_txn(1, 3, 16'hBEEF, 1'b0);
        check("rd_cpu_ack", 64'(cpu_ack), 64'd1);
        check("rd_apl_ack", 64'(apl_ack), 64'd0);
        check("rd_rdata",   64'(rdata),   64'hBEEF);
        cpu_req = 1'b0;
        step();
        check("rd_ack_one_cycle", 64'(cpu_ack),     64'd0);
        check("rd_rdata_hold",    64'(rdata),       64'hBEEF);
        check("rd_no_regrant",    64'(mem_req),     64'd0);
        check("rd_ack_count",     64'(cpu_ack_cnt), 64'd1);
        check("rd_req_count",     64'(mem_req_rises - r0), 64'd1);

        // simultaneous requests: Apple first
        step();
        apl_req = 1'b1; apl_we = 1'b1; apl_addr = 22'h000400; apl_wdata = 16'h1234; apl_wmask = 2'b11;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 22'h000777;
        r0 = mem_req_rises;
        wait_mem_req("sim_apl_req");
        check("sim_apl_addr",  64'(mem_addr),  64'h000400);
        check("sim_apl_we",    64'(mem_we),    64'd1);
        check("sim_apl_wdata", 64'(mem_wdata), 64'h1234);
        do_txn(0, 2, 16'h0000, 1'b0);
        check("sim_apl_ack", 64'({apl_ack, cpu_ack}), 64'd2);
        apl_req = 1'b0;
        wait_mem_req("sim_cpu_req");
        check("sim_cpu_addr", 64'(mem_addr), 64'h000777);
        check("sim_cpu_we",   64'(mem_we),   64'd0);
        do_txn(0, 0, 16'h5A5A, 1'b0);
        check("sim_cpu_ack",   64'({apl_ack, cpu_ack}), 64'd1);
        check("sim_cpu_rdata", 64'(rdata), 64'h5A5A);
        cpu_req = 1'b0;
        step();
        check("sim_req_count", 64'(mem_req_rises - r0), 64'd2);

        // same-cycle accept and done, partial write mask
        apl_req = 1'b1; apl_we = 1'b1; apl_addr = 22'h3FFFFF; apl_wdata = 16'hA5A5; apl_wmask = 2'b10;
        wait_mem_req("wm_req");
        check("wm_mask", 64'(mem_wmask), 64'd2);
        check("wm_addr", 64'(mem_addr),  64'h3FFFFF);
        do_txn(0, 0, 16'h0000, 1'b1);
        check("wm_ack_next_cycle", 64'(apl_ack), 64'd1);
        apl_req = 1'b0;
        step();
        check("wm_ack_pulse", 64'(apl_ack), 64'd0);

        // lock loss during WAIT_DONE
        c0 = cpu_ack_cnt;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 22'h000100;
        wait_mem_req("ll_req");
        mem_accept = 1'b1;
        step();
        mem_accept = 1'b0;
        check("ll_wait_done_no_req", 64'(mem_req), 64'd0);
        pll_lock = 1'b0;
        repeat (3) step();
        check("ll_ready_low", 64'(ready),   64'd0);
        check("ll_mem_req",   64'(mem_req), 64'd0);
        mem_done = 1'b1; mem_rdata = 16'hDEAD;
        step();
        mem_done = 1'b0;
        step();
        check("ll_stray_done_no_ack", 64'(cpu_ack),          64'd0);
        check("ll_rdata_kept",        64'(rdata),            64'd0);
        check("ll_no_ack_count",      64'(cpu_ack_cnt - c0), 64'd0);
        pll_lock = 1'b1;
        wait_ready("relock");
        wait_mem_req("ll_reissue_req");
        check("ll_reissue_addr", 64'(mem_addr), 64'h000100);
        do_txn(0, 1, 16'hC0DE, 1'b0);
        check("ll_cpu_ack", 64'(cpu_ack), 64'd1);
        check("ll_rdata",   64'(rdata),   64'hC0DE);
        cpu_req = 1'b0;
        step();
        check("ll_ack_once", 64'(cpu_ack_cnt - c0), 64'd1);

        // both requesters held: grant order depends on fairness build
        apl_req = 1'b1; apl_we = 1'b0; apl_addr = 22'h000AAA;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 22'h000CCC;
        for (int i = 0; i < 6; i++) begin
            wait_mem_req($sformatf("fair_req_%0d", i));
            check($sformatf("fair_addr_%0d", i), 64'(mem_addr),
                  exp_cpu[i] ? 64'h000CCC : 64'h000AAA);
            do_txn(0, 0, 16'(i), 1'b0);
            check($sformatf("fair_ack_%0d", i), 64'({apl_ack, cpu_ack}),
                  exp_cpu[i] ? 64'd1 : 64'd2);
        end
        apl_req = 1'b0;
        cpu_req = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
